// File: rtl/mips_fetch_stage.sv
// MIPS IF stage: issues instruction-SRAM reads from nextpc and holds the PC/instruction pair for decode.
// Define FE_INST_BUF_EN to latch the instruction during stalls instead of re-reading the SRAM.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfbffffc
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] nextpc,
  input  logic        de_allowin,
  input  logic        flush,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        fe_valid,
  output logic [31:0] fe_pc,
  output logic [31:0] fe_instruction,
  output logic        fe_allowin,
  output logic        fe_to_de_valid,
  output logic        fe_adel
);

  logic        started;
  logic        req;
  logic        buf_valid;
  logic [31:0] inst_buf;

  assign fe_allowin      = !fe_valid | de_allowin | flush;
  assign fe_to_de_valid  = fe_valid & !flush;
  assign req             = started & fe_allowin;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

`ifdef FE_INST_BUF_EN
  assign inst_sram_en   = req;
  assign inst_sram_addr = nextpc;
`else
  // Without a buffer the held word is re-read every stalled cycle.
  assign inst_sram_en   = started;
  assign inst_sram_addr = fe_allowin ? nextpc : fe_pc;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) started <= 1'b0;
    else         started <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fe_valid <= 1'b0;
      fe_pc    <= RESET_PC;
    end else if (req) begin
      fe_valid <= 1'b1;
      fe_pc    <= nextpc;
    end else if (fe_valid & de_allowin) begin
      fe_valid <= 1'b0;
    end
  end

`ifdef FE_INST_BUF_EN
  // Capture once on the first stall edge; the SRAM output is free to change afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      inst_buf  <= 32'b0;
    end else if (req | flush) begin
      buf_valid <= 1'b0;
    end else if (fe_valid & !de_allowin & !buf_valid) begin
      buf_valid <= 1'b1;
      inst_buf  <= inst_sram_rdata;
    end
  end
`else
  assign buf_valid = 1'b0;
  assign inst_buf  = 32'b0;
`endif

  assign fe_instruction = buf_valid ? inst_buf : inst_sram_rdata;
  assign fe_adel        = fe_valid & (fe_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed vector table, reset-mid-stall sequence, randomized run vs reference model.
module tb_mips_fetch_stage;

`ifdef FE_INST_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'hbfbffffc;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] nextpc = '0;
  logic        de_allowin = 1'b0;
  logic        flush = 1'b0;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = '0;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_instruction;
  logic        fe_allowin;
  logic        fe_to_de_valid;
  logic        fe_adel;

  int errors = 0;
  int checks = 0;

  mips_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn), .nextpc(nextpc), .de_allowin(de_allowin), .flush(flush),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_instruction(fe_instruction),
    .fe_allowin(fe_allowin), .fe_to_de_valid(fe_to_de_valid), .fe_adel(fe_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5a5a5a5a;
  endfunction

  // Synchronous-read SRAM; garbage on the output whenever no read was enabled.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] np;
    logic        da;
    logic        fl;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        ci;
    logic [31:0] inst;
    logic        to_de;
    logic        adel;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic [31:0] np, logic da, logic fl, logic en, logic [31:0] addr,
                              logic vld, logic [31:0] pc, logic ci, logic [31:0] inst,
                              logic to_de, logic adel);
    vec_t v;
    v.np = np; v.da = da; v.fl = fl; v.en = en; v.addr = addr; v.vld = vld; v.pc = pc;
    v.ci = ci; v.inst = inst; v.to_de = to_de; v.adel = adel;
    return v;
  endfunction

  // Apply row i now (just after an edge), check at the falling edge, return just after the next rising edge.
  task automatic apply_row(input int i);
    nextpc = tbl[i].np; de_allowin = tbl[i].da; flush = tbl[i].fl;
    @(negedge clk);
    chk($sformatf("row%0d en", i),    {31'b0, inst_sram_en},   {31'b0, tbl[i].en});
    if (tbl[i].en) chk($sformatf("row%0d addr", i), inst_sram_addr, tbl[i].addr);
    chk($sformatf("row%0d valid", i), {31'b0, fe_valid},       {31'b0, tbl[i].vld});
    chk($sformatf("row%0d pc", i),    fe_pc,                   tbl[i].pc);
    if (tbl[i].ci) chk($sformatf("row%0d inst", i), fe_instruction, tbl[i].inst);
    chk($sformatf("row%0d to_de", i), {31'b0, fe_to_de_valid}, {31'b0, tbl[i].to_de});
    chk($sformatf("row%0d adel", i),  {31'b0, fe_adel},        {31'b0, tbl[i].adel});
    @(posedge clk); #1;
  endtask

  logic        m_started, m_valid;
  logic [31:0] m_pc;

  initial begin
    logic        s_en;
    logic [31:0] inst_b, inst_c, inst_10, inst_14;
    s_en    = !BUF;
    inst_b  = 32'he59a5a5e;
    inst_c  = 32'he59a5a52;
    inst_10 = 32'he59a5a4a;
    inst_14 = 32'he59a5a4e;
    tbl[0]  = mk(32'hbfc00000, 1, 0, 0,    32'hbfc00000, 0, RST_PC,       0, 32'h0,        0, 0);
    tbl[1]  = mk(32'hbfc00000, 1, 0, 1,    32'hbfc00000, 0, RST_PC,       0, 32'h0,        0, 0);
    tbl[2]  = mk(32'hbfc00004, 1, 0, 1,    32'hbfc00004, 1, 32'hbfc00000, 1, 32'he59a5a5a, 1, 0);
    tbl[3]  = mk(32'hbfc00008, 0, 0, s_en, 32'hbfc00004, 1, 32'hbfc00004, 1, inst_b,       1, 0);
    tbl[4]  = tbl[3];
    tbl[5]  = tbl[3];
    tbl[6]  = mk(32'hbfc00008, 1, 0, 1,    32'hbfc00008, 1, 32'hbfc00004, 1, inst_b,       1, 0);
    tbl[7]  = mk(32'hbfc0000c, 0, 0, s_en, 32'hbfc00008, 1, 32'hbfc00008, 1, inst_c,       1, 0);
    tbl[8]  = mk(32'h80001000, 0, 1, 1,    32'h80001000, 1, 32'hbfc00008, 1, inst_c,       0, 0);
    tbl[9]  = mk(32'h80001004, 1, 0, 1,    32'h80001004, 1, 32'h80001000, 1, 32'hda5a4a5a, 1, 0);
    tbl[10] = mk(32'hbfc00006, 1, 0, 1,    32'hbfc00006, 1, 32'h80001004, 1, 32'hda5a4a5e, 1, 0);
    tbl[11] = mk(32'hbfc00010, 1, 0, 1,    32'hbfc00010, 1, 32'hbfc00006, 0, 32'h0,        1, 1);
    tbl[12] = mk(32'hbfc00014, 1, 0, 1,    32'hbfc00014, 1, 32'hbfc00010, 1, inst_10,      1, 0);
    tbl[13] = mk(32'hbfc00018, 0, 0, s_en, 32'hbfc00014, 1, 32'hbfc00014, 1, inst_14,      1, 0);
    tbl[14] = tbl[13];

    // The only stalled rows where the address matters are in the re-read build (addr = held PC).

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst valid", {31'b0, fe_valid}, 32'h0);
    chk("rst pc", fe_pc, RST_PC);
    chk("rst en", {31'b0, inst_sram_en}, 32'h0);
    chk("wen tie", {28'b0, inst_sram_wen}, 32'h0);
    chk("wdata tie", inst_sram_wdata, 32'h0);
    @(posedge clk); #1 resetn = 1'b1;

    for (int i = 0; i < 15; i++) apply_row(i);

    // Reset pulse in the middle of a stalled cycle.
    nextpc = 32'hbfc00018; de_allowin = 1'b0; flush = 1'b0;
    @(negedge clk); #2 resetn = 1'b0;
    #1;
    chk("midrst valid", {31'b0, fe_valid}, 32'h0);
    chk("midrst pc", fe_pc, RST_PC);
    chk("midrst en", {31'b0, inst_sram_en}, 32'h0);
    @(posedge clk); #1 resetn = 1'b1;
    for (int i = 0; i < 3; i++) apply_row(i);

    // Randomized run against the reference model, starting from a fresh reset.
    resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    m_started = 1'b0; m_valid = 1'b0; m_pc = RST_PC;
    for (int c = 0; c < 400; c++) begin
      logic        allow, e_en;
      logic [31:0] e_addr;
      int unsigned r;
      r          = $urandom % 16;
      de_allowin = ($urandom % 4) != 0;
      flush      = ($urandom % 8) == 0;
      if (flush)       nextpc = $urandom & 32'hfffffffc;
      else if (r == 0) nextpc = m_pc + 32'd6;
      else             nextpc = m_pc + 32'd4;

      allow  = !m_valid || de_allowin || flush;
      e_en   = BUF ? (m_started && allow) : m_started;
      e_addr = (!BUF && !allow) ? m_pc : nextpc;
      @(negedge clk);
      chk("rnd allowin", {31'b0, fe_allowin}, {31'b0, allow});
      chk("rnd en", {31'b0, inst_sram_en}, {31'b0, e_en});
      if (e_en) chk("rnd addr", inst_sram_addr, e_addr);
      chk("rnd valid", {31'b0, fe_valid}, {31'b0, m_valid});
      chk("rnd pc", fe_pc, m_pc);
      chk("rnd to_de", {31'b0, fe_to_de_valid}, {31'b0, m_valid && !flush});
      chk("rnd adel", {31'b0, fe_adel}, {31'b0, m_valid && (m_pc[1:0] != 2'b00)});
      if (m_valid && m_pc[1:0] == 2'b00) chk("rnd inst", fe_instruction, mem(m_pc));

      if (m_started && allow) begin
        m_valid = 1'b1;
        m_pc    = nextpc;
      end else if (m_valid && de_allowin) begin
        m_valid = 1'b0;
      end
      m_started = 1'b1;
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction-fetch (IF) stage of the five-stage MIPS pipeline. It takes the next-PC value computed from decode-stage state and turns it into instruction-SRAM read requests. It holds the fetched PC/instruction pair and presents it to decode under a valid/allowin handshake. It also drives the `fe_valid`, `fe_pc` and `fe_allowin` signals that the next-PC logic consumes.

## Interface
Parameters:
- `RESET_PC`, `32'hbfbffffc`: value loaded into `fe_pc` on reset (boot vector minus 4).

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `nextpc`  in  32  next fetch address from the next-PC logic.
- `de_allowin`  in  1  decode stage can accept an instruction this cycle.
- `flush`  in  1  redirect (ERET or exception); discard the current IF contents.
- `inst_sram_en`  out  1  instruction-SRAM read enable.
- `inst_sram_wen`  out  4  tied to `4'b0`.
- `inst_sram_addr`  out  32  read address.
- `inst_sram_wdata`  out  32  tied to `32'b0`.
- `inst_sram_rdata`  in  32  read data, valid one cycle after the enabled request.
- `fe_valid`  out  1  IF holds a fetched instruction.
- `fe_pc`  out  32  PC of the held instruction.
- `fe_instruction`  out  32  the held instruction word.
- `fe_allowin`  out  1  IF can accept a new fetch this cycle.
- `fe_to_de_valid`  out  1  instruction offered to decode.
- `fe_adel`  out  1  `fe_pc[1:0] != 0`; address-error flag travels with the instruction.

## Operation
- Internal state:
  - `started`: reset 0; set at the first clock edge with `resetn` high.
  - `fe_valid`: reset 0.
  - `fe_pc`: reset `RESET_PC`.
  - `buf_valid`: reset 0.
  - `inst_buf`: 32 bits, reset 0.
- `fe_allowin = !fe_valid | de_allowin | flush`.
- `fe_to_de_valid = fe_valid & !flush`.
- Request:
  - `inst_sram_en = started & fe_allowin`.
  - `inst_sram_addr = nextpc`.
  - No request is issued while `started` = 0.
- Fetch accept. At any edge with `inst_sram_en` = 1:
  - `fe_pc <= nextpc`, `fe_valid <= 1`, `buf_valid <= 0`.
- Drain. At an edge with `fe_valid & de_allowin` and no new request, `fe_valid <= 0`.
  - This occurs only when `started` = 0. In normal running, IF refills every cycle.
- Flush:
  - Combinationally blocks `fe_to_de_valid`.
  - Forces `fe_allowin` = 1, so the edge loads `nextpc`, which the next-PC logic has already steered to the redirect target.
  - Clears `buf_valid`.
- Output data: `fe_instruction = buf_valid ? inst_buf : inst_sram_rdata`.
- `fe_adel = fe_valid & (fe_pc[1:0] != 2'b00)`.
  - The request is still issued; the returned data is don't-care.
  - Decode/EX raise AdEL.
- `resetn` low at any time, including mid-stall:
  - All state returns to its reset value asynchronously.
  - `inst_sram_en` goes to 0 immediately.

## Timing
- Latency: request in cycle N → `fe_valid`/`fe_pc` update at the edge ending N → `fe_instruction` valid throughout N+1.
- Throughput: one instruction per cycle while `de_allowin` = 1.
- First fetch:
  - Cycle 0 = first cycle with `resetn` high: `started` = 0, no request.
  - Cycle 1: request to `nextpc` (`32'hbfc00000`, since `fe_valid` = 0).
  - Cycle 2: `fe_valid` = 1, `fe_pc` = `bfc00000`.
- Stall (`fe_valid` & `!de_allowin`):
  - `fe_pc`, `fe_valid` and `fe_instruction` hold.
  - No request is issued.
- Transfer to decode occurs on any edge where `fe_to_de_valid & de_allowin`.
- Simultaneous `flush` and `!de_allowin`: flush wins. A new request is issued and the old instruction is dropped.

## Configuration
- `FE_INST_BUF_EN` defined:
  - On the first stall edge (`fe_valid & !de_allowin & !buf_valid & !flush`): `inst_buf <= inst_sram_rdata`, `buf_valid <= 1`.
  - SRAM output may change during the stall.
- `FE_INST_BUF_EN` undefined:
  - No buffer; `buf_valid` is constant 0.
  - During a stall, `inst_sram_en = started` and `inst_sram_addr = fe_pc`, so the SRAM re-reads the held word every cycle.
  - When not stalled, enable and address follow the normal rules.
  - `fe_pc`/`fe_valid` behaviour is identical in both builds.

## Test plan
- Reset release, with the SRAM modelled as `mem[addr] = addr ^ 32'h5a5a5a5a` and `de_allowin` = 1:
  - No request in cycle 0.
  - `inst_sram_addr` = `bfc00000` in cycle 1.
  - Cycle 2: `fe_pc` = `bfc00000`, `fe_instruction` = `e59a5a5a`.
- Sequential stream with `nextpc` = `fe_pc` + 4: `fe_pc` steps `bfc00000`, `bfc00004`, `bfc00008`, one per cycle, with `fe_to_de_valid` = 1 every cycle.
- `de_allowin` = 0 for 3 cycles while holding `bfc00004`, with the SRAM driving garbage while `en` = 0 (buffer build):
  - `fe_pc` and `fe_instruction` stay constant for all 3 cycles.
  - `inst_sram_en` = 0 throughout the stall.
  - The next edge after `de_allowin` rises loads the new PC.
- `flush` with `nextpc` = `80001000` during a stall:
  - `fe_to_de_valid` = 0 that cycle.
  - Next cycle: `fe_pc` = `80001000`, `buf_valid` = 0.
- Misaligned `nextpc` = `bfc00006`: `fe_adel` = 1 in the following cycle, then 0 after an aligned fetch.
- `resetn` pulsed low mid-stall: `fe_valid` = 0 and `fe_pc` = `bfbffffc` immediately, and the restart follows the first-fetch timing.
